rad_async_fifo_wr_arb: RTL and testbench

- Write-side controller for the dual-clock async FIFO. Lives entirely in the wclk domain.
- Arbitrates NREQ valid/ready requesters onto the single memory write port, round-robin.
- Owns the binary/Gray write pointer and the registered full flag.
- Drives the memory's wdata/waddr/wclken/wfull and exports the Gray write pointer for the read-domain synchronizer.

---
 rtl/rad_async_fifo_wr_arb.sv | 154 +++++++++++++++
 tb/tb_rad_async_fifo_wr_arb.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/rad_async_fifo_wr_arb.sv
// rad_async_fifo_wr_arb: write-side controller for a dual-clock async FIFO.
// This block runs entirely in the wclk domain. It does three jobs:
//   - Arbitrates NREQ valid/ready requesters round-robin onto one memory write port.
//   - Owns the binary/Gray write pointer and the registered full flag.
//   - Exports the Gray write pointer for the read-domain synchronizer.
// Optional packet lock: define RAD_ASYNC_FIFO_WR_ARB_LOCK_EN to add req_last.
// A requester that is granted a beat with req_last=0 then keeps the port
// until its req_last=1 beat is accepted.
module rad_async_fifo_wr_arb #(
  parameter int DSIZE    = 8,
  parameter int ADDRSIZE = 3,
  parameter int NREQ     = 4
) (
  input  logic                       wclk,
  input  logic                       wrst_n,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ*DSIZE-1:0]      req_data,
`ifdef RAD_ASYNC_FIFO_WR_ARB_LOCK_EN
  input  logic [NREQ-1:0]            req_last,
`endif
  output logic [NREQ-1:0]            req_ready,
  input  logic [ADDRSIZE:0]          wq2_rptr,
  output logic [DSIZE-1:0]           wdata,
  output logic [ADDRSIZE-1:0]        waddr,
  output logic                       wclken,
  output logic                       wfull,
  output logic [ADDRSIZE:0]          wptr,
  output logic [$clog2(NREQ)-1:0]    grant_id
);

  localparam int GW = $clog2(NREQ);

  logic [ADDRSIZE:0] r_wbin;
  logic [ADDRSIZE:0] r_wptr;
  logic              r_wfull;
  logic [GW-1:0]     r_last_grant;

  logic [NREQ-1:0]   w_elig;
  logic              w_win_found;
  logic [GW-1:0]     w_win_id;
  int                w_cand;
  logic              w_grant_en;
  logic [ADDRSIZE:0] w_wbnext;
  logic [ADDRSIZE:0] w_wgnext;
  logic [ADDRSIZE:0] w_full_cmp;

`ifdef RAD_ASYNC_FIFO_WR_ARB_LOCK_EN
  typedef enum logic {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} lock_state_t;
  lock_state_t   r_state;
  logic [GW-1:0] r_lock_id;

  // While locked, only the lock holder is allowed to compete for the port.
  always_comb begin
    if (r_state == ST_LOCKED) begin
      w_elig = req_valid & ({{(NREQ-1){1'b0}}, 1'b1} << r_lock_id);
    end else begin
      w_elig = req_valid;
    end
  end

  // Packet lock FSM: enter on a non-last accepted beat, leave on the holder's last beat.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_state   <= ST_IDLE;
      r_lock_id <= {GW{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (wclken && !req_last[w_win_id]) begin
            r_state   <= ST_LOCKED;
            r_lock_id <= w_win_id;
          end
        end
        ST_LOCKED: begin
          if (wclken && req_last[w_win_id]) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end
`else
  // Without packet lock every valid requester competes each cycle.
  always_comb begin
    w_elig = req_valid;
  end
`endif

  // Round-robin search starting one past the last grantee; first eligible requester wins.
  always_comb begin
    w_win_found = 1'b0;
    w_win_id    = {GW{1'b0}};
    w_cand      = 0;
    for (int k = 1; k <= NREQ; k++) begin
      w_cand = (int'(r_last_grant) + k) % NREQ;
      if (!w_win_found && w_elig[w_cand]) begin
        w_win_found = 1'b1;
        w_win_id    = GW'(w_cand);
      end
    end
  end

  // No grant while in reset or while the FIFO is full.
  assign w_grant_en = wrst_n & ~r_wfull & w_win_found;

  // Ready is one-hot on the winner, or all-zero when nothing is granted.
  always_comb begin
    if (w_grant_en) begin
      req_ready = {{(NREQ-1){1'b0}}, 1'b1} << w_win_id;
    end else begin
      req_ready = {NREQ{1'b0}};
    end
  end

  assign wclken   = |(req_valid & req_ready);
  assign wdata    = req_data[w_win_id*DSIZE +: DSIZE];
  assign waddr    = r_wbin[ADDRSIZE-1:0];
  assign wfull    = r_wfull;
  assign wptr     = r_wptr;
  assign grant_id = w_win_id;

  assign w_wbnext = r_wbin + {{ADDRSIZE{1'b0}}, wclken};
  assign w_wgnext = w_wbnext ^ (w_wbnext >> 1);

  // Full when the next Gray write pointer equals the read pointer with its top two bits inverted.
  generate
    if (ADDRSIZE == 1) begin : g_cmp_narrow
      assign w_full_cmp = ~wq2_rptr;
    end else begin : g_cmp_wide
      assign w_full_cmp = {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]};
    end
  endgenerate

  // Pointer, full flag and round-robin state; pointers advance only on an accepted beat.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_wbin       <= {(ADDRSIZE+1){1'b0}};
      r_wptr       <= {(ADDRSIZE+1){1'b0}};
      r_wfull      <= 1'b0;
      r_last_grant <= GW'(NREQ - 1);
    end else begin
      if (wclken) begin
        r_wbin       <= w_wbnext;
        r_wptr       <= w_wgnext;
        r_last_grant <= w_win_id;
      end
      r_wfull <= (w_wgnext == w_full_cmp);
    end
  end

endmodule

// File: tb/tb_rad_async_fifo_wr_arb.sv
// Directed bench for rad_async_fifo_wr_arb (DSIZE=8, ADDRSIZE=3, NREQ=4).
// Also builds with RAD_ASYNC_FIFO_WR_ARB_LOCK_EN defined, which adds the packet-lock scenario.
module tb_rad_async_fifo_wr_arb;

  logic        wclk;
  logic        wrst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
`ifdef RAD_ASYNC_FIFO_WR_ARB_LOCK_EN
  logic [3:0]  req_last;
`endif
  logic [3:0]  req_ready;
  logic [3:0]  wq2_rptr;
  logic [7:0]  wdata;
  logic [2:0]  waddr;
  logic        wclken;
  logic        wfull;
  logic [3:0]  wptr;
  logic [1:0]  grant_id;

  int n_total;
  int n_bad;

  rad_async_fifo_wr_arb #(.DSIZE(8), .ADDRSIZE(3), .NREQ(4)) dut (
    .wclk      (wclk),
    .wrst_n    (wrst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
`ifdef RAD_ASYNC_FIFO_WR_ARB_LOCK_EN
    .req_last  (req_last),
`endif
    .req_ready (req_ready),
    .wq2_rptr  (wq2_rptr),
    .wdata     (wdata),
    .waddr     (waddr),
    .wclken    (wclken),
    .wfull     (wfull),
    .wptr      (wptr),
    .grant_id  (grant_id)
  );

  // Free-running write clock.
  always #5 wclk = ~wclk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] bin2gray(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic pulse_reset();
    @(negedge wclk);
    wrst_n = 1'b0;
    @(negedge wclk);
    wrst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] rr_ptr [4];
    logic [3:0] d1, d2, prev;
    logic [1:0] grants [4];
    logic [1:0] exp_grants [4];

    n_total = 0;
    n_bad   = 0;
    rr_ptr  = '{4'h1, 4'h3, 4'h2, 4'h6};
    wclk      = 1'b0;
    wrst_n    = 1'b0;
    req_valid = 4'hF;
    req_data  = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    wq2_rptr  = 4'h0;
`ifdef RAD_ASYNC_FIFO_WR_ARB_LOCK_EN
    req_last  = 4'hF;
`endif

    // Reset held with all valids high.
    repeat (2) @(negedge wclk);
    #1;
    check_val("rst_ready", 32'(req_ready), 32'h0);
    check_val("rst_wclken", 32'(wclken), 32'h0);
    check_val("rst_wptr", 32'(wptr), 32'h0);
    check_val("rst_wfull", 32'(wfull), 32'h0);
    check_val("rst_waddr", 32'(waddr), 32'h0);

    // Round-robin over all four requesters.
    @(negedge wclk);
    wrst_n = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      check_val("rr_grant", 32'(grant_id), 32'(i));
      check_val("rr_ready", 32'(req_ready), 32'(1 << i));
      check_val("rr_waddr", 32'(waddr), 32'(i));
      check_val("rr_wdata", 32'(wdata), 32'(8'hA0 + 8'h11 * i));
      check_val("rr_wclken", 32'(wclken), 32'h1);
      @(posedge wclk);
      #1;
      check_val("rr_wptr", 32'(wptr), 32'(rr_ptr[i]));
      @(negedge wclk);
      #1;
    end

    // Reset asserted mid-stream clears the pointer without a clock edge.
    wrst_n = 1'b0;
    #1;
    check_val("async_rst_wptr", 32'(wptr), 32'h0);
    check_val("async_rst_ready", 32'(req_ready), 32'h0);
    @(negedge wclk);
    wrst_n = 1'b1;

    // Fill: requester 2 alone, eight beats.
    req_valid = 4'b0100;
    #1;
    for (int i = 0; i < 8; i++) begin
      check_val("fill_grant", 32'(grant_id), 32'h2);
      check_val("fill_waddr", 32'(waddr), 32'(i));
      check_val("fill_wfull_pre", 32'(wfull), 32'h0);
      @(posedge wclk);
      @(negedge wclk);
      #1;
    end
    check_val("fill_wfull", 32'(wfull), 32'h1);
    check_val("fill_wptr", 32'(wptr), 32'hC);
    check_val("full_ready", 32'(req_ready), 32'h0);
    check_val("full_wclken", 32'(wclken), 32'h0);
    @(posedge wclk);
    #1;
    check_val("full_hold_wptr", 32'(wptr), 32'hC);

    // Release: reader advances by one entry.
    @(negedge wclk);
    wq2_rptr = 4'b0001;
    #1;
    check_val("rel_wfull_pre", 32'(wfull), 32'h1);
    @(posedge wclk);
    #1;
    check_val("rel_wfull", 32'(wfull), 32'h0);
    check_val("rel_ready", 32'(req_ready), 32'h4);
    check_val("rel_waddr", 32'(waddr), 32'h0);
    @(posedge wclk);
    #1;
    check_val("rel_refull", 32'(wfull), 32'h1);
    check_val("rel_wptr", 32'(wptr), 32'hD);

    // Wrap: 20 beats with the read pointer following two cycles behind.
    wq2_rptr = 4'h0;
    pulse_reset();
    req_valid = 4'b0001;
    d1 = 4'h0;
    d2 = 4'h0;
    prev = 4'h0;
    #1;
    for (int b = 1; b <= 20; b++) begin
      check_val("wrap_waddr", 32'(waddr), 32'((b - 1) % 8));
      check_val("wrap_wfull", 32'(wfull), 32'h0);
      check_val("wrap_wclken", 32'(wclken), 32'h1);
      @(posedge wclk);
      #1;
      check_val("wrap_wptr", 32'(wptr), 32'(bin2gray(4'(b))));
      check_val("wrap_onebit", 32'($countones(wptr ^ prev)), 32'h1);
      if (b == 8) check_val("wrap_msb8", 32'(wptr[3]), 32'h1);
      if (b == 16) check_val("wrap_msb16", 32'(wptr[3]), 32'h0);
      prev = wptr;
      wq2_rptr = d2;
      d2 = d1;
      d1 = wptr;
    end

    // Two requesters; requester 0 sends a three-beat packet.
    wq2_rptr = 4'h0;
    pulse_reset();
    req_valid = 4'b0011;
`ifdef RAD_ASYNC_FIFO_WR_ARB_LOCK_EN
    exp_grants = '{2'd0, 2'd0, 2'd0, 2'd1};
    req_last = 4'b0010;
`else
    exp_grants = '{2'd0, 2'd1, 2'd0, 2'd1};
`endif
    #1;
    for (int i = 0; i < 4; i++) begin
`ifdef RAD_ASYNC_FIFO_WR_ARB_LOCK_EN
      req_last[0] = (i == 2);
      #1;
`endif
      grants[i] = grant_id;
      check_val("pkt_grant", 32'(grants[i]), 32'(exp_grants[i]));
      check_val("pkt_wclken", 32'(wclken), 32'h1);
      @(posedge wclk);
      @(negedge wclk);
`ifdef RAD_ASYNC_FIFO_WR_ARB_LOCK_EN
      if (i == 0) begin
        // Lock holder idles: the other requester must still be refused.
        req_valid = 4'b0010;
        #1;
        check_val("lock_idle_ready", 32'(req_ready), 32'h0);
        check_val("lock_idle_wclken", 32'(wclken), 32'h0);
        @(posedge wclk);
        @(negedge wclk);
        req_valid = 4'b0011;
      end
`endif
      #1;
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
